qos_scheduler: RTL and testbench
================================

Name: qos_scheduler

Overview:
- Weighted round-robin read scheduler for four 6-deep, 2-bit class buffers (class 3 = highest priority, class 0 = lowest).
- Once per rising edge of the slow service clock clk3sn, exactly one buffer is allowed to transmit.
- Drives each buffer's level-sensitive rd input, collects the dequeued packet, and forwards it as a single output stream.
- Sits between the four class buffers and the transmit/display logic.

Parameters:
- W3, 4: credits per round for class 3
- W2, 3: credits per round for class 2
- W1, 2: credits per round for class 1
- W0, 1: credits per round for class 0
- CW, 3: credit counter width; every Wi must be in 1..2^CW-1
- OUT_TO, 3: clk cycles to wait for the granted buffer's out_en before declaring a miss

Ports:
- clk  in  1  system clock; rising edge
- rst_n  in  1  asynchronous active-low reset
- clk3sn  in  1  slow service clock, synchronous to clk, held high for at least 2 clk cycles
- data_count  in  12  packed buffer occupancy, {cnt3,cnt2,cnt1,cnt0}, 3 bits each, range 0..6
- buf_data  in  8  packed buffer outputs, {d3,d2,d1,d0}, 2 bits each
- buf_out_en  in  4  per-buffer out_en
- rd  out  4  one-hot or zero; level read request to the buffers
- tx_data  out  2  forwarded packet
- tx_class  out  2  class of tx_data
- tx_valid  out  1  one-cycle pulse when tx_data/tx_class are valid
- idle_ticks  out  7  clk3sn edges with no grant; wraps 127->0
- miss_count  out  7  grants where out_en never arrived; wraps 127->0

Behaviour:
- Reset (async assert, sync release) sets:
  - rd=0, tx_data=0, tx_class=0, tx_valid=0, idle_ticks=0, miss_count=0
  - credits = {W3,W2,W1,W0}
  - prev3 (last sampled clk3sn) = 0, state=ARB
- Edge detect: at each clk, prev3 <= clk3sn; edge = (prev3==0 && clk3sn==1). This matches the buffer's sampling edge E.
- Eligibility: class i is eligible when cnt_i != 0 and credit_i != 0.
- Selection: highest eligible class wins.
  - If no class is eligible but some cnt_i != 0, all credits reload to {W3..W0} in the same cycle and selection uses the reloaded values.
  - If every cnt_i == 0, no class is selected.
- States:
  - ARB:
    - Computes the selection and registers rd = onehot(sel), or 0 if none. Goes to HOLD next cycle.
  - HOLD:
    - rd stays stable. Occupancy changes are ignored until the next ARB.
    - On edge with rd != 0: go to WAIT, timer = 0.
    - On edge with rd == 0: idle_ticks++, go to ARB.
    - If in HOLD, rd != 0, and the granted cnt_i becomes 0 before an edge: go to ARB (re-arbitrate).
  - WAIT:
    - rd stays held; timer++ each cycle.
    - If buf_out_en[g] == 1: tx_data = d_g, tx_class = g, tx_valid = 1 for one cycle; credit_g--; go to ARB.
    - If timer == OUT_TO - 1 with no out_en: miss_count++; credit unchanged; go to ARB.
- Latency: with the buffer's registered read, tx_valid rises at E+2 clk (buffer out_en at E+1 is sampled at E+2).
- rd is cleared in the ARB cycle, well before the next clk3sn edge (at least 2 clk).
- A credit never underflows, because decrement happens only on a successful grant with credit != 0.
- Counters wrap modulo 128 and never saturate.
- Reset mid-WAIT: the packet is abandoned with no tx_valid. A buffer that already dequeued loses it, which is acceptable.
- Starvation bound: a nonempty class i waits at most sum(Wj, j≠i) grants.

Decomposition:
- Package qos_pkg holds:
  - state enum {ARB, HOLD, WAIT}
  - NCLASS=4
  - data width 2, count width 3, stats width 7
  - default weights
- One natural sub-module: qos_prio_pick, a combinational 4-input highest-eligible picker that outputs onehot and index.

Test Plan:
- All buffers empty, 5 clk3sn edges -> rd=0 throughout, idle_ticks=5, no tx_valid.
- cnt3=6, others 0, 4 edges -> rd=4'b1000 each time, 4 tx_valid with tx_class=3, credit3 = 4 -> 0, then reload on the 5th arbitration.
- All counts 6, default weights, 10 edges -> grant classes 3,3,3,3,2,2,2,1,1,0 in that order.
- Granted class 3, buf_out_en held 0 -> after OUT_TO cycles miss_count=1, credit3 still 4, back in ARB.
- cnt1=2 granted; cnt1 forced to 0 while in HOLD, cnt0=1 -> re-arbitrate, rd=4'b0001 before the edge, tx_class=0.
- rst_n pulsed low mid-WAIT -> all outputs and credits return to reset values immediately, no tx_valid.

Source files
------------

// File: rtl/qos_pkg.sv
// Shared types and constants for the weighted round-robin QoS read scheduler.
package qos_pkg;

    localparam int unsigned NCLASS = 4;  // number of class buffers
    localparam int unsigned DATA_W = 2;  // packet width per buffer
    localparam int unsigned CNT_W  = 3;  // buffer occupancy width
    localparam int unsigned STAT_W = 7;  // statistics counter width
    localparam int unsigned IDX_W  = 2;  // class index width

    // Default credits per round, class 3 highest priority.
    localparam int unsigned DEF_W3 = 4;
    localparam int unsigned DEF_W2 = 3;
    localparam int unsigned DEF_W1 = 2;
    localparam int unsigned DEF_W0 = 1;

    typedef enum logic [1:0] {
        StArb,
        StHold,
        StWait
    } state_e;

endpackage

// File: rtl/qos_prio_pick.sv
// Combinational highest-index picker: class 3 wins over class 0.
module qos_prio_pick
    import qos_pkg::*;
(
    input  logic [NCLASS-1:0] req_i,
    output logic [NCLASS-1:0] onehot_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              valid_o
);

    // Scan upwards so the highest requesting class overwrites lower ones.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        for (int i = 0; i < NCLASS; i++) begin
            if (req_i[i]) begin
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
                idx_o       = IDX_W'(i);
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qos_scheduler.sv
// Weighted round-robin read scheduler: one grant per clk3sn rising edge,
// forwards the dequeued packet as a single tagged stream.
module qos_scheduler
    import qos_pkg::*;
#(
    parameter int unsigned W3     = DEF_W3,
    parameter int unsigned W2     = DEF_W2,
    parameter int unsigned W1     = DEF_W1,
    parameter int unsigned W0     = DEF_W0,
    parameter int unsigned CW     = 3,
    parameter int unsigned OUT_TO = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clk3sn,
    input  logic [NCLASS*CNT_W-1:0]   data_count,
    input  logic [NCLASS*DATA_W-1:0]  buf_data,
    input  logic [NCLASS-1:0]         buf_out_en,
    output logic [NCLASS-1:0]         rd,
    output logic [DATA_W-1:0]         tx_data,
    output logic [IDX_W-1:0]          tx_class,
    output logic                      tx_valid,
    output logic [STAT_W-1:0]         idle_ticks,
    output logic [STAT_W-1:0]         miss_count
);

    localparam int unsigned TmrW = (OUT_TO > 1) ? $clog2(OUT_TO) : 1;
    localparam logic [NCLASS-1:0][CW-1:0] Weights = {CW'(W3), CW'(W2), CW'(W1), CW'(W0)};

    state_e                   state_q, state_d;
    logic [NCLASS-1:0]        rd_q, rd_d;
    logic [IDX_W-1:0]         grant_q, grant_d;
    logic [NCLASS-1:0][CW-1:0] credit_q, credit_d;
    logic [TmrW-1:0]          timer_q, timer_d;
    logic [DATA_W-1:0]        tx_data_q, tx_data_d;
    logic [IDX_W-1:0]         tx_class_q, tx_class_d;
    logic                     tx_valid_q, tx_valid_d;
    logic [STAT_W-1:0]        idle_q, idle_d;
    logic [STAT_W-1:0]        miss_q, miss_d;
    logic                     prev3_q;

    logic                     clk3_edge;
    logic [NCLASS-1:0]        nonempty, elig, cand;
    logic                     reload;
    logic [NCLASS-1:0]        pick_onehot;
    logic [IDX_W-1:0]         pick_idx;
    logic                     pick_valid;
    logic [DATA_W-1:0]        grant_data;

    assign clk3_edge = !prev3_q && clk3sn;

    // Per-class occupancy/credit eligibility and the granted buffer's data lane.
    always_comb begin
        nonempty   = '0;
        elig       = '0;
        grant_data = '0;
        for (int i = 0; i < NCLASS; i++) begin
            nonempty[i] = (data_count[i*CNT_W +: CNT_W] != '0);
            elig[i]     = nonempty[i] && (credit_q[i] != '0);
            if (grant_q == IDX_W'(i)) begin
                grant_data = buf_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Round exhausted but work pending: pick against freshly reloaded credits.
    assign reload = (elig == '0) && (nonempty != '0);
    assign cand   = reload ? nonempty : elig;

    qos_prio_pick u_pick (
        .req_i    (cand),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    // Arbitration FSM: next state, grant, credits and statistics.
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        grant_d    = grant_q;
        credit_d   = credit_q;
        timer_d    = timer_q;
        tx_data_d  = tx_data_q;
        tx_class_d = tx_class_q;
        tx_valid_d = 1'b0;
        idle_d     = idle_q;
        miss_d     = miss_q;
        unique case (state_q)
            StArb: begin
                if (reload) begin
                    credit_d = Weights;
                end
                rd_d    = pick_valid ? pick_onehot : '0;
                grant_d = pick_idx;
                state_d = StHold;
            end
            StHold: begin
                if (clk3_edge) begin
                    if (rd_q != '0) begin
                        timer_d = '0;
                        state_d = StWait;
                    end else begin
                        idle_d  = idle_q + 1'b1;
                        state_d = StArb;
                    end
                end else if ((rd_q != '0) && !nonempty[grant_q]) begin
                    // Granted buffer drained before the edge: choose again.
                    rd_d    = '0;
                    state_d = StArb;
                end
            end
            StWait: begin
                timer_d = timer_q + 1'b1;
                if (buf_out_en[grant_q]) begin
                    tx_data_d  = grant_data;
                    tx_class_d = grant_q;
                    tx_valid_d = 1'b1;
                    if (credit_q[grant_q] != '0) begin
                        credit_d[grant_q] = credit_q[grant_q] - 1'b1;
                    end
                    rd_d    = '0;
                    state_d = StArb;
                end else if (timer_q == TmrW'(OUT_TO - 1)) begin
                    miss_d  = miss_q + 1'b1;
                    rd_d    = '0;
                    state_d = StArb;
                end
            end
            default: begin
                rd_d    = '0;
                state_d = StArb;
            end
        endcase
    end

    // State and output registers, async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StArb;
            rd_q       <= '0;
            grant_q    <= '0;
            credit_q   <= Weights;
            timer_q    <= '0;
            tx_data_q  <= '0;
            tx_class_q <= '0;
            tx_valid_q <= 1'b0;
            idle_q     <= '0;
            miss_q     <= '0;
            prev3_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            grant_q    <= grant_d;
            credit_q   <= credit_d;
            timer_q    <= timer_d;
            tx_data_q  <= tx_data_d;
            tx_class_q <= tx_class_d;
            tx_valid_q <= tx_valid_d;
            idle_q     <= idle_d;
            miss_q     <= miss_d;
            prev3_q    <= clk3sn;
        end
    end

    assign rd         = rd_q;
    assign tx_data    = tx_data_q;
    assign tx_class   = tx_class_q;
    assign tx_valid   = tx_valid_q;
    assign idle_ticks = idle_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_qos_scheduler.sv
// Bench for qos_scheduler: behavioural class buffers, a reference WRR model
// feeding a scoreboard, a vector table and hand-written corner sequences.
module tb_qos_scheduler;
    import qos_pkg::*;

    localparam int unsigned OutTo = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk3sn;
    logic [11:0] data_count;
    logic [7:0]  buf_data;
    logic [3:0]  buf_out_en;
    logic [3:0]  rd;
    logic [1:0]  tx_data;
    logic [1:0]  tx_class;
    logic        tx_valid;
    logic [6:0]  idle_ticks;
    logic [6:0]  miss_count;

    qos_scheduler #(
        .W3     (4),
        .W2     (3),
        .W1     (2),
        .W0     (1),
        .CW     (3),
        .OUT_TO (OutTo)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk3sn     (clk3sn),
        .data_count (data_count),
        .buf_data   (buf_data),
        .buf_out_en (buf_out_en),
        .rd         (rd),
        .tx_data    (tx_data),
        .tx_class   (tx_class),
        .tx_valid   (tx_valid),
        .idle_ticks (idle_ticks),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] cls;
        logic [1:0] data;
    } exp_t;

    typedef struct {
        logic [11:0] counts;
        logic [3:0]  exp_rd;
        int          exp_tx;
        int          exp_cls;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    int         cnt [4];
    int         ref_cred [4];
    logic [3:0] pend;
    logic       tb_prev3;
    bit         drop_en;
    logic [3:0] last_edge_rd;
    int         tx_seen = 0;
    exp_t       sb_q [$];
    vec_t       vecs [6];
    int         exp_order [10];

    function automatic int wt(input int i);
        case (i)
            3: return 4;
            2: return 3;
            1: return 2;
            default: return 1;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference weighted round-robin selection from the bench's own counts.
    task automatic ref_pick(output logic [3:0] oh, output int idx);
        bit any_ne;
        bit any_el;
        any_ne = 1'b0;
        any_el = 1'b0;
        oh     = '0;
        idx    = -1;
        for (int i = 0; i < 4; i++) begin
            if (cnt[i] > 0) any_ne = 1'b1;
            if (cnt[i] > 0 && ref_cred[i] > 0) any_el = 1'b1;
        end
        if (!any_el && any_ne) begin
            for (int i = 0; i < 4; i++) ref_cred[i] = wt(i);
        end
        for (int i = 3; i >= 0; i--) begin
            if (idx < 0 && cnt[i] > 0 && ref_cred[i] > 0) idx = i;
        end
        if (idx >= 0) oh[idx] = 1'b1;
    endtask

    // One clk cycle: scoreboard the output, then model the buffers.
    task automatic tick();
        logic [3:0] rd_pre;
        logic       c3_pre;
        logic [3:0] exp_oh;
        int         exp_idx;
        exp_t       e;
        rd_pre = rd;
        c3_pre = clk3sn;
        @(posedge clk);
        #1;
        if (tx_valid) begin
            tx_seen++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got tx_valid=1 class=%0d, required no transfer",
                         tx_class);
            end else begin
                e = sb_q.pop_front();
                check("tx_class", int'(tx_class), int'(e.cls));
                check("tx_data", int'(tx_data), int'(e.data));
            end
        end
        buf_out_en = pend;
        pend       = '0;
        if (rst_n && !tb_prev3 && c3_pre) begin
            last_edge_rd = rd_pre;
            ref_pick(exp_oh, exp_idx);
            check("rd_at_edge", int'(rd_pre), int'(exp_oh));
            if (exp_idx >= 0 && !drop_en) begin
                e.cls  = 2'(exp_idx);
                e.data = 2'(cnt[exp_idx] + exp_idx);
                sb_q.push_back(e);
                ref_cred[exp_idx]--;
            end
            if (!drop_en) begin
                for (int i = 0; i < 4; i++) begin
                    if (rd_pre[i] && cnt[i] > 0) begin
                        buf_data[i*2 +: 2] = 2'(cnt[i] + i);
                        cnt[i]--;
                        pend[i] = 1'b1;
                    end
                end
            end
        end
        tb_prev3 = c3_pre;
        for (int i = 0; i < 4; i++) data_count[i*3 +: 3] = 3'(cnt[i]);
    endtask

    task automatic do_reset(input logic [11:0] counts);
        rst_n      = 1'b0;
        clk3sn     = 1'b0;
        drop_en    = 1'b0;
        buf_out_en = '0;
        buf_data   = '0;
        pend       = '0;
        tb_prev3   = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 4; i++) begin
            cnt[i]      = int'(counts[i*3 +: 3]);
            ref_cred[i] = wt(i);
        end
        data_count = counts;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    // One full slow-clock period: 4 cycles high, 4 low.
    task automatic run_edge();
        clk3sn = 1'b1;
        repeat (4) tick();
        clk3sn = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int tx0;
        vecs[0] = '{12'h000, 4'b0000, 0, 0};
        vecs[1] = '{{3'd6, 3'd0, 3'd0, 3'd0}, 4'b1000, 1, 3};
        vecs[2] = '{{3'd0, 3'd6, 3'd6, 3'd6}, 4'b0100, 1, 2};
        vecs[3] = '{{3'd0, 3'd0, 3'd0, 3'd1}, 4'b0001, 1, 0};
        vecs[4] = '{{3'd0, 3'd0, 3'd1, 3'd5}, 4'b0010, 1, 1};
        vecs[5] = '{{3'd1, 3'd1, 3'd1, 3'd1}, 4'b1000, 1, 3};
        exp_order = '{3, 3, 3, 3, 2, 2, 2, 1, 1, 0};

        // Reset state.
        do_reset(12'h000);
        check("reset_rd", int'(rd), 0);
        check("reset_tx_valid", int'(tx_valid), 0);
        check("reset_tx_data", int'(tx_data), 0);
        check("reset_tx_class", int'(tx_class), 0);
        check("reset_idle", int'(idle_ticks), 0);
        check("reset_miss", int'(miss_count), 0);
        check("reset_credit3", int'(dut.credit_q[3]), 4);
        check("reset_credit0", int'(dut.credit_q[0]), 1);

        // Vector table: single arbitration from fresh credits.
        for (int v = 0; v < 6; v++) begin
            do_reset(vecs[v].counts);
            tx0 = tx_seen;
            run_edge();
            check("vec_rd", int'(last_edge_rd), int'(vecs[v].exp_rd));
            check("vec_tx_count", tx_seen - tx0, vecs[v].exp_tx);
            check("vec_idle", int'(idle_ticks), (vecs[v].exp_tx == 0) ? 1 : 0);
            if (vecs[v].exp_tx != 0) check("vec_class", int'(tx_class), vecs[v].exp_cls);
        end

        // All empty for five edges.
        do_reset(12'h000);
        tx0 = tx_seen;
        repeat (5) run_edge();
        check("empty_idle", int'(idle_ticks), 5);
        check("empty_tx", tx_seen - tx0, 0);
        check("empty_miss", int'(miss_count), 0);

        // Class 3 alone: four grants drain its credit, fifth arbitration reloads.
        do_reset({3'd6, 3'd0, 3'd0, 3'd0});
        tx0 = tx_seen;
        repeat (3) run_edge();
        clk3sn = 1'b1;
        tick();
        tick();
        tick();
        check("latency_tx_valid", int'(tx_valid), 1);
        check("credit3_drained", int'(dut.credit_q[3]), 0);
        tick();
        check("credit3_reloaded", int'(dut.credit_q[3]), 4);
        check("rd_after_reload", int'(rd), 4'b1000);
        tick();
        clk3sn = 1'b0;
        repeat (4) tick();
        check("c3_tx_count", tx_seen - tx0, 4);
        run_edge();
        check("c3_fifth_rd", int'(last_edge_rd), 4'b1000);
        check("c3_tx_count5", tx_seen - tx0, 5);

        // All full: grant order over ten edges.
        do_reset({3'd6, 3'd6, 3'd6, 3'd6});
        tx0 = tx_seen;
        for (int k = 0; k < 10; k++) begin
            run_edge();
            check("order_rd", int'(last_edge_rd), 1 << exp_order[k]);
            check("order_class", int'(tx_class), exp_order[k]);
        end
        check("order_tx_count", tx_seen - tx0, 10);

        // Missing out_en: timeout, miss counted, credit kept, back to arbitration.
        do_reset({3'd6, 3'd0, 3'd0, 3'd0});
        drop_en = 1'b1;
        tx0 = tx_seen;
        clk3sn = 1'b1;
        tick();
        tick();
        tick();
        check("miss_early", int'(miss_count), 0);
        tick();
        check("miss_count", int'(miss_count), 1);
        check("miss_state_arb", int'(dut.state_q), int'(StArb));
        check("miss_credit3", int'(dut.credit_q[3]), 4);
        clk3sn = 1'b0;
        repeat (4) tick();
        check("miss_no_tx", tx_seen - tx0, 0);
        drop_en = 1'b0;
        run_edge();
        check("after_miss_rd", int'(last_edge_rd), 4'b1000);

        // Granted class drains while held: re-arbitrate before the edge.
        do_reset({3'd0, 3'd0, 3'd2, 3'd1});
        check("rearb_initial_rd", int'(rd), 4'b0010);
        cnt[1] = 0;
        data_count = {3'd0, 3'd0, 3'd0, 3'd1};
        tick();
        tick();
        tick();
        check("rearb_rd", int'(rd), 4'b0001);
        tx0 = tx_seen;
        run_edge();
        check("rearb_tx_count", tx_seen - tx0, 1);
        check("rearb_class", int'(tx_class), 0);

        // Reset asserted while waiting for out_en.
        do_reset({3'd6, 3'd0, 3'd0, 3'd0});
        run_edge();
        run_edge();
        check("pre_reset_credit3", int'(dut.credit_q[3]), 2);
        clk3sn = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midwait_rd", int'(rd), 0);
        check("midwait_tx_valid", int'(tx_valid), 0);
        check("midwait_tx_class", int'(tx_class), 0);
        check("midwait_tx_data", int'(tx_data), 0);
        check("midwait_idle", int'(idle_ticks), 0);
        check("midwait_state", int'(dut.state_q), int'(StArb));
        check("midwait_credit3", int'(dut.credit_q[3]), 4);
        tx0 = tx_seen;
        do_reset({3'd4, 3'd0, 3'd0, 3'd0});
        repeat (4) tick();
        check("midwait_no_tx", tx_seen - tx0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
